// File: rtl/assoc_layer_learner.sv
// Associative layer: clears and learns a saturating class-to-class weight table,
// then answers recall queries with a one-column-per-cycle argmax scan.
module assoc_layer_learner #(
  parameter int NUM_CLASSES = 16,
  parameter int CLASS_W     = 4,
  parameter int WEIGHT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                assoc_learning_start,
  output logic                assoc_learning_done,
  input  logic                pair_valid,
  output logic                pair_ready,
  input  logic [CLASS_W-1:0]  key_class,
  input  logic [CLASS_W-1:0]  resp_class,
  input  logic                pair_last,
  input  logic                query_valid,
  output logic                query_ready,
  input  logic [CLASS_W-1:0]  query_class,
  output logic                result_valid,
  output logic [CLASS_W-1:0]  result_class,
  output logic [WEIGHT_W-1:0] result_weight,
  output logic                result_found
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LEARN, S_READY, S_SCAN} state_t;

  localparam logic [CLASS_W:0]    NC       = NUM_CLASSES[CLASS_W:0];
  localparam logic [CLASS_W-1:0]  LAST_IDX = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [WEIGHT_W-1:0] W_MAX    = '1;

  state_t                state_q, state_d;
  logic [CLASS_W-1:0]    cnt_q, cnt_d;
  logic [CLASS_W-1:0]    query_q, query_d;
  logic [WEIGHT_W-1:0]   max_w_q, max_w_d;
  logic [CLASS_W-1:0]    max_c_q, max_c_d;
  logic                  found_q, found_d;
  logic                  res_valid_q, res_valid_d;
  logic [CLASS_W-1:0]    res_class_q, res_class_d;
  logic [WEIGHT_W-1:0]   res_weight_q, res_weight_d;
  logic                  res_found_q, res_found_d;

  logic [WEIGHT_W-1:0]   wt_q [NUM_CLASSES][NUM_CLASSES];

  logic                  cnt_last;
  logic                  pair_ok;
  logic                  clr_en;
  logic                  upd_en;
  logic [WEIGHT_W-1:0]   cur_w;

  assign cnt_last = (cnt_q == LAST_IDX);
  assign pair_ok  = (key_class != resp_class) &&
                    ({1'b0, key_class} < NC) && ({1'b0, resp_class} < NC);
  // Out-of-range query rows read as all-zero, so the scan reports not-found.
  assign cur_w    = ({1'b0, query_q} < NC) ? wt_q[query_q][cnt_q] : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    query_d      = query_q;
    max_w_d      = max_w_q;
    max_c_d      = max_c_q;
    found_d      = found_q;
    res_valid_d  = 1'b0;
    res_class_d  = res_class_q;
    res_weight_d = res_weight_q;
    res_found_d  = res_found_q;
    clr_en       = 1'b0;
    upd_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (assoc_learning_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_en = 1'b1;
        if (cnt_last) begin
          state_d = S_LEARN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LEARN: begin
        if (pair_valid) begin
          upd_en = pair_ok;
          if (pair_last) state_d = S_READY;
        end
      end
      S_READY: begin
        if (assoc_learning_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (query_valid) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          query_d = query_class;
          max_w_d = '0;
          max_c_d = '0;
          found_d = 1'b0;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest column on ties.
        if (cur_w > max_w_q) begin
          max_w_d = cur_w;
          max_c_d = cnt_q;
          found_d = 1'b1;
        end
        if (cnt_last) begin
          state_d      = S_READY;
          res_valid_d  = 1'b1;
          res_class_d  = max_c_d;
          res_weight_d = max_w_d;
          res_found_d  = found_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      query_q      <= '0;
      max_w_q      <= '0;
      max_c_q      <= '0;
      found_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_weight_q <= '0;
      res_found_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      query_q      <= query_d;
      max_w_q      <= max_w_d;
      max_c_q      <= max_c_d;
      found_q      <= found_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      res_weight_q <= res_weight_d;
      res_found_q  <= res_found_d;
    end
  end

  // Table storage survives reset; only CLEAR wipes it.
  always_ff @(posedge clk) begin
    if (!reset && clr_en) begin
      for (int i = 0; i < NUM_CLASSES; i++) wt_q[cnt_q][i] <= '0;
    end else if (!reset && upd_en && (wt_q[key_class][resp_class] != W_MAX)) begin
      wt_q[key_class][resp_class] <= wt_q[key_class][resp_class] + 1'b1;
    end
  end

  assign assoc_learning_done = (state_q == S_READY);
  assign query_ready         = (state_q == S_READY);
  assign pair_ready          = (state_q == S_LEARN);
  assign result_valid        = res_valid_q;
  assign result_class        = res_class_q;
  assign result_weight       = res_weight_q;
  assign result_found        = res_found_q;

endmodule

// File: tb/tb_assoc_layer_learner.sv
// Bench for assoc_layer_learner: scenario tasks checked against a table model.
module tb_assoc_layer_learner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       assoc_learning_start = 1'b0;
  logic       assoc_learning_done;
  logic       pair_valid = 1'b0;
  logic       pair_ready;
  logic [3:0] key_class = '0;
  logic [3:0] resp_class = '0;
  logic       pair_last = 1'b0;
  logic       query_valid = 1'b0;
  logic       query_ready;
  logic [3:0] query_class = '0;
  logic       result_valid;
  logic [3:0] result_class;
  logic [7:0] result_weight;
  logic       result_found;

  int errors = 0;
  int checks = 0;
  int mw [16][16];

  always #5 clk = ~clk;

  assoc_layer_learner #(.NUM_CLASSES(16), .CLASS_W(4), .WEIGHT_W(8)) dut (
    .clk(clk), .reset(reset),
    .assoc_learning_start(assoc_learning_start), .assoc_learning_done(assoc_learning_done),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .key_class(key_class), .resp_class(resp_class), .pair_last(pair_last),
    .query_valid(query_valid), .query_ready(query_ready), .query_class(query_class),
    .result_valid(result_valid), .result_class(result_class),
    .result_weight(result_weight), .result_found(result_found)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 16; k++)
      for (int r = 0; r < 16; r++) mw[k][r] = 0;
  endfunction

  function automatic void model_pair(int k, int r);
    if (k != r && k < 16 && r < 16 && mw[k][r] < 255) mw[k][r] = mw[k][r] + 1;
  endfunction

  // Best response = first class holding the row maximum; nothing found if max is 0.
  function automatic void model_query(int q, output int c, output int w, output int f);
    int mx;
    mx = 0; c = 0; w = 0; f = 0;
    if (q < 16) begin
      foreach (mw[q][r]) if (mw[q][r] > mx) mx = mw[q][r];
      if (mx > 0) begin
        f = 1; w = mx;
        for (int r = 15; r >= 0; r--) if (mw[q][r] == mx) c = r;
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Pulses start and counts cycles until pair_ready; flags any done seen meanwhile.
  task automatic start_learn(output int lat, output int done_seen);
    assoc_learning_start = 1'b1;
    step();
    assoc_learning_start = 1'b0;
    model_clear();
    lat = 1; done_seen = 0;
    while (!pair_ready && lat < 40) begin
      if (assoc_learning_done) done_seen = 1;
      step();
      lat++;
    end
  endtask

  task automatic send_pair(int k, int r, bit last, bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    key_class = 4'(k); resp_class = 4'(r); pair_last = last; pair_valid = 1'b1;
    n = 0;
    while (!pair_ready && n < 50) begin step(); n++; end
    step();
    pair_valid = 1'b0; pair_last = 1'b0;
    model_pair(k, r);
  endtask

  task automatic do_query(int q, output int c, output int w, output int f, output int lat);
    query_class = 4'(q); query_valid = 1'b1;
    step();
    query_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin step(); lat++; end
    c = result_class; w = result_weight; f = result_found;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({assoc_learning_done, pair_ready, query_ready, result_valid} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=0000", {assoc_learning_done, pair_ready, query_ready, result_valid}); end
    checks++; if ({result_class, result_weight, result_found} !== 13'b0) begin errors++; $display("FAIL reset_result got=%h want=0", {result_class, result_weight, result_found}); end
  endtask

  task automatic test_clear_len();
    int lat, ds;
    start_learn(lat, ds);
    checks++; if (lat !== 17) begin errors++; $display("FAIL clear_len got=%0d want=17", lat); end
    checks++; if (ds !== 0) begin errors++; $display("FAIL clear_done got=%0d want=0", ds); end
  endtask

  task automatic test_learn_recall();
    int c, w, f, lat, ec, ew, ef;
    repeat (3) send_pair(3, 5, 0, 0);
    repeat (2) send_pair(3, 7, 0, 0);
    send_pair(3, 5, 1, 0);
    checks++; if (assoc_learning_done !== 1'b1) begin errors++; $display("FAIL learn_done got=%b want=1", assoc_learning_done); end
    model_query(3, ec, ew, ef);
    do_query(3, c, w, f, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL recall_lat got=%0d want=17", lat); end
    checks++; if (c !== ec || w !== ew || f !== ef) begin errors++; $display("FAIL recall3 got=%0d/%0d/%0d want=%0d/%0d/%0d", c, w, f, ec, ew, ef); end
    checks++; if (ec !== 5 || ew !== 4) begin errors++; $display("FAIL recall3_model got=%0d/%0d want=5/4", ec, ew); end
    step();
    checks++; if (result_valid !== 1'b0 || result_class !== 4'd5 || result_weight !== 8'd4) begin errors++; $display("FAIL result_hold got=%b/%0d/%0d want=0/5/4", result_valid, result_class, result_weight); end
  endtask

  task automatic test_tie_self();
    int c, w, f, lat, ds;
    start_learn(lat, ds);
    repeat (2) send_pair(2, 9, 0, 1);
    repeat (2) send_pair(2, 4, 0, 1);
    for (int i = 0; i < 5; i++) send_pair(2, 2, (i == 4), 1);
    checks++; if (assoc_learning_done !== 1'b1) begin errors++; $display("FAIL tie_done got=%b want=1", assoc_learning_done); end
    do_query(2, c, w, f, lat);
    checks++; if (c !== 4 || w !== 2 || f !== 1) begin errors++; $display("FAIL tie got=%0d/%0d/%0d want=4/2/1", c, w, f); end
    do_query(0, c, w, f, lat);
    checks++; if (c !== 0 || w !== 0 || f !== 0) begin errors++; $display("FAIL empty_row got=%0d/%0d/%0d want=0/0/0", c, w, f); end
  endtask

  task automatic test_saturation();
    int c, w, f, lat, ds;
    start_learn(lat, ds);
    for (int i = 0; i < 300; i++) send_pair(1, 6, (i == 299), 1);
    do_query(1, c, w, f, lat);
    checks++; if (c !== 6 || w !== 255 || f !== 1) begin errors++; $display("FAIL saturate got=%0d/%0d/%0d want=6/255/1", c, w, f); end
  endtask

  task automatic test_restart_priority();
    int c, w, f, lat, rv;
    assoc_learning_start = 1'b1; query_valid = 1'b1; query_class = 4'd1;
    step();
    assoc_learning_start = 1'b0; query_valid = 1'b0;
    model_clear();
    checks++; if (assoc_learning_done !== 1'b0 || query_ready !== 1'b0) begin errors++; $display("FAIL restart_done got=%b%b want=00", assoc_learning_done, query_ready); end
    lat = 1; rv = 0;
    while (!pair_ready && lat < 40) begin
      if (result_valid) rv = 1;
      step(); lat++;
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL dropped_query got=%0d want=0", rv); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL restart_len got=%0d want=17", lat); end
    send_pair(8, 1, 1, 0);
    do_query(3, c, w, f, lat);
    checks++; if (c !== 0 || w !== 0 || f !== 0) begin errors++; $display("FAIL cleared got=%0d/%0d/%0d want=0/0/0", c, w, f); end
    do_query(8, c, w, f, lat);
    checks++; if (c !== 1 || w !== 1 || f !== 1) begin errors++; $display("FAIL relearn got=%0d/%0d/%0d want=1/1/1", c, w, f); end
  endtask

  task automatic test_reset_mid();
    int c, w, f, lat, ds, rv;
    query_class = 4'd8; query_valid = 1'b1;
    step();
    query_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({assoc_learning_done, pair_ready, query_ready, result_valid, result_class, result_weight, result_found} !== 17'b0) begin errors++; $display("FAIL reset_mid got=%h want=0", {assoc_learning_done, pair_ready, query_ready, result_valid, result_class, result_weight, result_found}); end
    rv = 0;
    repeat (20) begin
      if (result_valid || assoc_learning_done || pair_ready) rv = 1;
      step();
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL reset_idle got=%0d want=0", rv); end
    start_learn(lat, ds);
    checks++; if (lat !== 17) begin errors++; $display("FAIL reset_relearn_len got=%0d want=17", lat); end
    repeat (2) send_pair(4, 12, 0, 1);
    send_pair(4, 3, 1, 1);
    do_query(4, c, w, f, lat);
    checks++; if (c !== 12 || w !== 2 || f !== 1 || lat !== 17) begin errors++; $display("FAIL reset_recover got=%0d/%0d/%0d lat=%0d want=12/2/1 lat=17", c, w, f, lat); end
  endtask

  task automatic test_random();
    int c, w, f, lat, ds, ec, ew, ef;
    start_learn(lat, ds);
    for (int i = 0; i < 80; i++)
      send_pair($urandom_range(0, 5), $urandom_range(0, 5), (i == 79), 1);
    for (int q = 0; q < 8; q++) begin
      model_query(q, ec, ew, ef);
      do_query(q, c, w, f, lat);
      checks++; if (c !== ec || w !== ew || f !== ef) begin errors++; $display("FAIL random_q%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", q, c, w, f, ec, ew, ef); end
    end
  endtask

  initial begin
    test_reset();
    test_clear_len();
    test_learn_recall();
    test_tie_self();
    test_saturation();
    test_restart_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
